// File: rtl/boot_ctrl_pkg.sv
// Shared types for the boot/programming session controller: FSM states,
// the memory request bundle carried through the port mux, and sizing helpers.
package boot_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN,
        HALT,
        PROGRAM,
        DRAIN,
        BOOT
    } boot_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam mem_req_t MEM_IDLE = '0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the
// clock domain; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boot_session_ctrl.sv
// Owns the instruction-memory write port: core traffic in RUN, UART programmer
// traffic during a session, then holds the core in reset and reboots it.
module boot_session_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter logic [31:0] PROGRAMMER_START_ADDR = 32'h0000_0800,
    parameter int unsigned IDLE_TIMEOUT_CYCLES   = 5_000_000,
    parameter int unsigned RESET_HOLD_CYCLES     = 16,
    parameter int unsigned DRAIN_CYCLES          = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        programmer_enable_i,
    output logic        programmer_enable_o,
    input  logic        prog_write_enable_i,
    input  logic [31:0] prog_write_addr_i,
    input  logic [31:0] prog_write_data_i,
    input  logic        core_mem_req_i,
    input  logic        core_mem_we_i,
    input  logic [3:0]  core_mem_be_i,
    input  logic [31:0] core_mem_addr_i,
    input  logic [31:0] core_mem_wdata_i,
    output logic        core_mem_gnt_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_reset_no,
    output logic [31:0] boot_addr_o,
    output logic        busy_o,
    output logic [15:0] words_written_o,
    output logic        prog_drop_o
);

    localparam int unsigned HOLD_W = width_for(max_u(RESET_HOLD_CYCLES, DRAIN_CYCLES));
    localparam int unsigned IDLE_W = width_for(IDLE_TIMEOUT_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((RESET_HOLD_CYCLES > 0) ? RESET_HOLD_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] DRAIN_LAST =
        HOLD_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_ON = (IDLE_TIMEOUT_CYCLES != 0);

    boot_state_e       state;
    boot_state_e       state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [15:0]       words;
    logic              drop_q;
    logic              en_s;
    logic              en_q;
    logic              en_rise;
    logic              prog_owns;
    logic              prog_write;
    logic              idle_hit;
    mem_req_t          mem_sel;

    sync_2ff #(
        .WIDTH(1)
    ) u_en_sync (
        .clk  (clk_i),
        .rst_n(reset_ni),
        .d    (programmer_enable_i),
        .q    (en_s)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_s;
        end
    end

    assign en_rise    = en_s & ~en_q;
    assign prog_owns  = (state == PROGRAM) || (state == DRAIN);
    assign prog_write = prog_owns & prog_write_enable_i;
    // Timeout only ends a session that actually wrote something.
    assign idle_hit   = TIMEOUT_ON && (idle_cnt == IDLE_MAX) && (words != 16'h0000);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (en_rise) state_next = HALT;
            HALT:    state_next = PROGRAM;
            PROGRAM: if (!en_s || idle_hit) state_next = DRAIN;
            DRAIN:   if (hold_cnt == DRAIN_LAST) state_next = BOOT;
            BOOT:    if (hold_cnt == HOLD_LAST) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // One counter serves both timed states; it restarts on every state change.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_cnt <= '0;
        end else if ((state_next != state) || !((state == DRAIN) || (state == BOOT))) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idle_cnt <= '0;
        end else if (state == HALT) begin
            idle_cnt <= '0;
        end else if (state == PROGRAM) begin
            if (prog_write_enable_i) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            words  <= 16'h0000;
            drop_q <= 1'b0;
        end else begin
            drop_q <= prog_write_enable_i & ~prog_owns;
            if (state == HALT) begin
                words <= 16'h0000;
            end else if (prog_write && (words != 16'hFFFF)) begin
                words <= words + 16'h0001;
            end
        end
    end

    always_comb begin
        mem_sel             = MEM_IDLE;
        core_mem_gnt_o      = 1'b0;
        core_reset_no       = 1'b0;
        programmer_enable_o = 1'b0;
        busy_o              = 1'b1;
        case (state)
            RUN: begin
                mem_sel        = '{req:   core_mem_req_i,
                                   we:    core_mem_we_i,
                                   be:    core_mem_be_i,
                                   addr:  core_mem_addr_i,
                                   wdata: core_mem_wdata_i};
                core_mem_gnt_o = core_mem_req_i;
                core_reset_no  = 1'b1;
                busy_o         = 1'b0;
            end
            PROGRAM, DRAIN: begin
                mem_sel             = '{req:   prog_write_enable_i,
                                        we:    prog_write_enable_i,
                                        be:    4'hF,
                                        addr:  prog_write_addr_i,
                                        wdata: prog_write_data_i};
                programmer_enable_o = (state == PROGRAM);
            end
            default: begin
                mem_sel = MEM_IDLE;
            end
        endcase
    end

    assign mem_req_o       = mem_sel.req;
    assign mem_we_o        = mem_sel.we;
    assign mem_be_o        = mem_sel.be;
    assign mem_addr_o      = mem_sel.addr;
    assign mem_wdata_o     = mem_sel.wdata;
    assign boot_addr_o     = PROGRAMMER_START_ADDR;
    assign words_written_o = words;
    assign prog_drop_o     = drop_q;

endmodule

// File: tb/tb_boot_session_ctrl.sv
// Randomised bench for boot_session_ctrl: expected writes, counts and
// latencies are derived from the session rules, not from the RTL internals.
module tb_boot_session_ctrl;

    localparam logic [31:0] START   = 32'h0000_0800;
    localparam int          IDLE_T  = 1000;
    localparam int          HOLD_T  = 16;
    localparam int          DRAIN_T = 8;
    localparam int          SYNC_T  = 2;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        programmer_enable_i;
    logic        programmer_enable_o;
    logic        prog_write_enable_i;
    logic [31:0] prog_write_addr_i;
    logic [31:0] prog_write_data_i;
    logic        core_mem_req_i;
    logic        core_mem_we_i;
    logic [3:0]  core_mem_be_i;
    logic [31:0] core_mem_addr_i;
    logic [31:0] core_mem_wdata_i;
    logic        core_mem_gnt_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_reset_no;
    logic [31:0] boot_addr_o;
    logic        busy_o;
    logic [15:0] words_written_o;
    logic        prog_drop_o;

    int checks;
    int errors;
    int drop_count;
    int gnt_leak;
    int rst_leak;
    bit core_noise;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [3:0]  cap_be[$];
    logic [31:0] exp_data[$];

    boot_session_ctrl #(
        .PROGRAMMER_START_ADDR(START),
        .IDLE_TIMEOUT_CYCLES  (IDLE_T),
        .RESET_HOLD_CYCLES    (HOLD_T),
        .DRAIN_CYCLES         (DRAIN_T)
    ) dut (
        .clk_i              (clk),
        .reset_ni           (reset_ni),
        .programmer_enable_i(programmer_enable_i),
        .programmer_enable_o(programmer_enable_o),
        .prog_write_enable_i(prog_write_enable_i),
        .prog_write_addr_i  (prog_write_addr_i),
        .prog_write_data_i  (prog_write_data_i),
        .core_mem_req_i     (core_mem_req_i),
        .core_mem_we_i      (core_mem_we_i),
        .core_mem_be_i      (core_mem_be_i),
        .core_mem_addr_i    (core_mem_addr_i),
        .core_mem_wdata_i   (core_mem_wdata_i),
        .core_mem_gnt_o     (core_mem_gnt_o),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_be_o           (mem_be_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .core_reset_no      (core_reset_no),
        .boot_addr_o        (boot_addr_o),
        .busy_o             (busy_o),
        .words_written_o    (words_written_o),
        .prog_drop_o        (prog_drop_o)
    );

    always #5 clk = ~clk;

    // Passive monitor: records every write the memory sees while a session owns the port.
    always @(negedge clk) begin
        if (reset_ni && busy_o) begin
            if (mem_req_o && mem_we_o) begin
                cap_addr.push_back(mem_addr_o);
                cap_data.push_back(mem_wdata_o);
                cap_be.push_back(mem_be_o);
            end
            if (core_mem_gnt_o) gnt_leak++;
            if (core_reset_no) rst_leak++;
        end
        if (prog_drop_o) drop_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (core_noise) begin
            core_mem_req_i   = 1'b1;
            core_mem_we_i    = 1'b1;
            core_mem_be_i    = 4'($urandom_range(15, 0));
            core_mem_addr_i  = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
            core_mem_wdata_i = $urandom;
        end
    endtask

    function automatic logic sigVal(input int which);
        return (which == 0) ? programmer_enable_o : core_reset_no;
    endfunction

    // Counts clock edges until the selected output reaches level, bounded by limit.
    task automatic waitSignal(input int which, input logic level, input int limit, output int n);
        n = 0;
        while (sigVal(which) !== level && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        prog_write_enable_i = 1'b1;
        prog_write_addr_i   = addr;
        prog_write_data_i   = data;
        tick();
        prog_write_enable_i = 1'b0;
    endtask

    task automatic clearCapture();
        cap_addr.delete();
        cap_data.delete();
        cap_be.delete();
        gnt_leak = 0;
        rst_leak = 0;
    endtask

    task automatic compareCapture(input string tag);
        checkOutput({tag, "_count"}, cap_addr.size(), exp_data.size());
        for (int i = 0; i < cap_addr.size() && i < exp_data.size(); i++) begin
            checkOutput({tag, "_addr"}, cap_addr[i], START + 32'(4 * i));
            checkOutput({tag, "_data"}, cap_data[i], exp_data[i]);
            checkOutput({tag, "_be"}, 32'(cap_be[i]), 32'hF);
        end
        checkOutput({tag, "_gnt_leak"}, gnt_leak, 0);
        checkOutput({tag, "_core_rst_leak"}, rst_leak, 0);
    endtask

    // Full pin-driven session; exp_data holds the words, extra_drain adds one write after exit.
    task automatic runSession(input string tag, input int max_gap, input bit extra_drain);
        int n;
        int nprog;
        clearCapture();
        core_noise = 1'b1;
        nprog = exp_data.size();
        if (extra_drain) exp_data.push_back($urandom);
        programmer_enable_i = 1'b1;
        waitSignal(0, 1'b1, 20, n);
        checkOutput({tag, "_entry_latency"}, n, SYNC_T + 2);
        checkOutput({tag, "_words_cleared"}, words_written_o, 0);
        for (int i = 0; i < nprog; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            applyStimulus(START + 32'(4 * i), exp_data[i]);
        end
        programmer_enable_i = 1'b0;
        if (extra_drain) begin
            repeat (SYNC_T + 1) tick();
            checkOutput({tag, "_drain_penable"}, programmer_enable_o, 0);
            applyStimulus(START + 32'(4 * nprog), exp_data[nprog]);
            waitSignal(1, 1'b1, 100, n);
            checkOutput({tag, "_reboot_latency"}, n + SYNC_T + 2, SYNC_T + 1 + DRAIN_T + HOLD_T);
        end else begin
            waitSignal(1, 1'b1, 100, n);
            checkOutput({tag, "_reboot_latency"}, n, SYNC_T + 1 + DRAIN_T + HOLD_T);
        end
        core_noise     = 1'b0;
        core_mem_req_i = 1'b0;
        checkOutput({tag, "_words"}, words_written_o, exp_data.size());
        checkOutput({tag, "_busy"}, busy_o, 0);
        compareCapture(tag);
    endtask

    initial begin
        int n;
        int drops0;
        logic [31:0] d;
        logic [3:0]  b;

        checks = 0;
        errors = 0;
        drop_count = 0;
        core_noise = 1'b0;
        reset_ni = 1'b0;
        programmer_enable_i = 1'b0;
        prog_write_enable_i = 1'b0;
        prog_write_addr_i = '0;
        prog_write_data_i = '0;
        core_mem_req_i = 1'b0;
        core_mem_we_i = 1'b0;
        core_mem_be_i = '0;
        core_mem_addr_i = '0;
        core_mem_wdata_i = '0;

        repeat (3) tick();
        checkOutput("rst_core_reset", core_reset_no, 0);
        checkOutput("rst_penable", programmer_enable_o, 0);
        checkOutput("rst_mem_req", mem_req_o, 0);
        checkOutput("rst_gnt", core_mem_gnt_o, 0);
        checkOutput("rst_words", words_written_o, 0);
        checkOutput("rst_drop", prog_drop_o, 0);
        checkOutput("rst_busy", busy_o, 1);
        checkOutput("boot_addr", boot_addr_o, START);

        reset_ni = 1'b1;
        waitSignal(1, 1'b1, 50, n);
        checkOutput("poweron_hold", n, HOLD_T);
        checkOutput("run_busy", busy_o, 0);

        d = $urandom;
        b = 4'($urandom_range(15, 0));
        core_mem_req_i = 1'b1;
        core_mem_we_i = 1'b1;
        core_mem_be_i = b;
        core_mem_addr_i = 32'h0000_1000;
        core_mem_wdata_i = d;
        #1;
        checkOutput("run_mem_req", mem_req_o, 1);
        checkOutput("run_mem_we", mem_we_o, 1);
        checkOutput("run_mem_addr", mem_addr_o, 32'h0000_1000);
        checkOutput("run_mem_data", mem_wdata_o, d);
        checkOutput("run_mem_be", 32'(mem_be_o), 32'(b));
        checkOutput("run_gnt", core_mem_gnt_o, 1);
        tick();
        core_mem_req_i = 1'b0;
        #1;
        checkOutput("run_idle_req", mem_req_o, 0);
        checkOutput("run_idle_gnt", core_mem_gnt_o, 0);

        drops0 = drop_count;
        prog_write_enable_i = 1'b1;
        prog_write_addr_i = START;
        prog_write_data_i = $urandom;
        #1;
        checkOutput("drop_no_mem_req", mem_req_o, 0);
        tick();
        core_mem_req_i = 1'b1;
        core_mem_addr_i = 32'h0000_2000;
        #1;
        checkOutput("drop_core_addr", mem_addr_o, 32'h0000_2000);
        checkOutput("drop_core_data", mem_wdata_o, core_mem_wdata_i);
        tick();
        prog_write_enable_i = 1'b0;
        core_mem_req_i = 1'b0;
        repeat (3) tick();
        checkOutput("drop_pulses", drop_count - drops0, 2);

        exp_data = '{32'h3322_1100, 32'h7766_5544, 32'hbbaa_9988, 32'hdead_beaf};
        runSession("fixed", 0, 1'b0);

        for (int s = 0; s < 3; s++) begin
            exp_data.delete();
            repeat ($urandom_range(6, 1)) exp_data.push_back($urandom);
            runSession("rand", 3, s[0]);
            repeat ($urandom_range(5, 1)) tick();
        end

        // Idle timeout with the pin held high, then edge-only re-entry.
        clearCapture();
        exp_data = '{$urandom, $urandom};
        core_noise = 1'b1;
        programmer_enable_i = 1'b1;
        waitSignal(0, 1'b1, 20, n);
        checkOutput("to_entry_latency", n, SYNC_T + 2);
        applyStimulus(START, exp_data[0]);
        repeat (5) tick();
        applyStimulus(START + 32'd4, exp_data[1]);
        waitSignal(0, 1'b0, IDLE_T + 100, n);
        checkOutput("to_exit_latency", n, IDLE_T + 1);
        checkOutput("to_words", words_written_o, 2);
        waitSignal(1, 1'b1, 100, n);
        checkOutput("to_reboot_latency", n, DRAIN_T + HOLD_T);
        core_noise = 1'b0;
        core_mem_req_i = 1'b0;
        compareCapture("to");
        repeat (20) tick();
        checkOutput("to_no_reentry_busy", busy_o, 0);
        checkOutput("to_no_reentry_pen", programmer_enable_o, 0);
        programmer_enable_i = 1'b0;
        repeat (4) tick();
        programmer_enable_i = 1'b1;
        waitSignal(0, 1'b1, 20, n);
        checkOutput("reentry_latency", n, SYNC_T + 2);
        checkOutput("reentry_words", words_written_o, 0);
        repeat (IDLE_T + 50) tick();
        checkOutput("no_timeout_without_words", programmer_enable_o, 1);
        programmer_enable_i = 1'b0;
        waitSignal(1, 1'b1, 100, n);
        checkOutput("reentry_reboot_latency", n, SYNC_T + 1 + DRAIN_T + HOLD_T);

        // Asynchronous reset in the middle of a session.
        programmer_enable_i = 1'b1;
        waitSignal(0, 1'b1, 20, n);
        checkOutput("mid_entry_latency", n, SYNC_T + 2);
        applyStimulus(START, $urandom);
        applyStimulus(START + 32'd4, $urandom);
        checkOutput("mid_words", words_written_o, 2);
        prog_write_enable_i = 1'b1;
        core_mem_req_i = 1'b1;
        #1;
        reset_ni = 1'b0;
        #1;
        checkOutput("mid_rst_words", words_written_o, 0);
        checkOutput("mid_rst_core_reset", core_reset_no, 0);
        checkOutput("mid_rst_penable", programmer_enable_o, 0);
        checkOutput("mid_rst_mem_req", mem_req_o, 0);
        checkOutput("mid_rst_gnt", core_mem_gnt_o, 0);
        checkOutput("mid_rst_drop", prog_drop_o, 0);
        prog_write_enable_i = 1'b0;
        core_mem_req_i = 1'b0;
        programmer_enable_i = 1'b0;
        repeat (3) tick();
        reset_ni = 1'b1;
        waitSignal(1, 1'b1, 50, n);
        checkOutput("mid_rst_hold", n, HOLD_T);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
